// File: rtl/fsm_control_seq_if.sv
// Instruction handshake and datapath-control bundle for fsm_control_seq.
// The master side issues instructions; the slave side (the sequencer)
// returns register numbers, datapath strobes and status.
interface fsm_control_seq_if #(
    parameter int REG_W = 4,
    parameter int OP_W  = 4
);
    logic                    w;
    logic [OP_W+2*REG_W-1:0] instruction_F;
    logic [REG_W-1:0]        reg_x_num;
    logic [REG_W-1:0]        reg_y_num;
    logic                    R_in;
    logic                    Rx_out;
    logic                    Ry_out;
    logic                    A_in;
    logic                    G_in;
    logic                    G_out;
    logic                    Extern;
    logic [1:0]              AddXor;
    logic                    busy;
    logic                    done;
    logic                    illegal;

    modport master (
        output w, instruction_F,
        input  reg_x_num, reg_y_num, R_in, Rx_out, Ry_out, A_in, G_in,
               G_out, Extern, AddXor, busy, done, illegal
    );

    modport slave (
        input  w, instruction_F,
        output reg_x_num, reg_y_num, R_in, Rx_out, Ry_out, A_in, G_in,
               G_out, Extern, AddXor, busy, done, illegal
    );
endinterface

// File: rtl/fsm_control_seq.sv
// Control sequencer for the simple CPU datapath. Latches {opcode, X, Y}
// on a w handshake and steps IDLE -> T1 [-> T2 -> T3], producing Moore
// strobes decoded from the state and the latched opcode. A new instruction
// may be accepted in the done cycle, so w held high issues back-to-back.
module fsm_control_seq #(
    parameter int REG_W = 4,
    parameter int OP_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    fsm_control_seq_if.slave      bus
);

    typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_LOAD = 3'd1,
        OP_MOVE = 3'd2,
        OP_ADD  = 3'd3,
        OP_XOR  = 3'd4,
        OP_SUB  = 3'd5,
        OP_AND  = 3'd6,
        OP_ILL  = 3'd7
    } opcode_t;

    localparam int INSTR_W = OP_W + 2*REG_W;

    state_t          state;
    state_t          state_next;
    logic [OP_W-1:0] op_q;
    opcode_t         op_lo;
    logic            op_legal;
    logic            is_alu;
    logic            accept;

    // Decoded controls, gathered locally and then driven onto the bundle.
    logic       r_in_c, rx_out_c, ry_out_c, a_in_c, g_in_c, g_out_c, extern_c;
    logic [1:0] add_xor_c;
    logic       done_c, illegal_c;

    // Only opcodes 0..6 with all upper opcode bits clear are defined.
    assign op_lo    = opcode_t'(op_q[2:0]);
    assign op_legal = ((op_q >> 3) == '0) && (op_lo != OP_ILL);
    assign is_alu   = op_legal && (op_lo == OP_ADD || op_lo == OP_XOR ||
                                   op_lo == OP_SUB || op_lo == OP_AND);

    // State register and instruction latch; fields load only on acceptance.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            op_q          <= '0;
            bus.reg_x_num <= '0;
            bus.reg_y_num <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_q          <= bus.instruction_F[INSTR_W-1 -: OP_W];
                bus.reg_x_num <= bus.instruction_F[2*REG_W-1 -: REG_W];
                bus.reg_y_num <= bus.instruction_F[REG_W-1:0];
            end
        end
    end

    // Moore output decode plus next-state; acceptance wins over return to IDLE.
    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        r_in_c     = 1'b0;
        rx_out_c   = 1'b0;
        ry_out_c   = 1'b0;
        a_in_c     = 1'b0;
        g_in_c     = 1'b0;
        g_out_c    = 1'b0;
        extern_c   = 1'b0;
        add_xor_c  = 2'b00;
        done_c     = 1'b0;
        illegal_c  = 1'b0;
        state_next = state;

        unique case (state)
            IDLE: ;
            T1: begin
                if (!op_legal) begin
                    done_c    = 1'b1;
                    illegal_c = 1'b1;
                end else if (is_alu) begin
                    rx_out_c = 1'b1;
                    a_in_c   = 1'b1;
                end else begin
                    done_c = 1'b1;
                    case (op_lo)
                        OP_LOAD: begin
                            extern_c = 1'b1;
                            r_in_c   = 1'b1;
                        end
                        OP_MOVE: begin
                            ry_out_c = 1'b1;
                            r_in_c   = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            T2: begin
                ry_out_c = 1'b1;
                g_in_c   = 1'b1;
                case (op_lo)
                    OP_XOR:  add_xor_c = 2'b01;
                    OP_SUB:  add_xor_c = 2'b10;
                    OP_AND:  add_xor_c = 2'b11;
                    default: add_xor_c = 2'b00;
                endcase
            end
            T3: begin
                g_out_c = 1'b1;
                r_in_c  = 1'b1;
                done_c  = 1'b1;
            end
            default: ;
        endcase

        accept = bus.w && (state == IDLE || done_c);

        if (accept) begin
            state_next = T1;
        end else if (done_c) begin
            state_next = IDLE;
        end else begin
            case (state)
                T1:      state_next = T2;
                T2:      state_next = T3;
                default: state_next = IDLE;
            endcase
        end
    end

    assign bus.R_in    = r_in_c;
    assign bus.Rx_out  = rx_out_c;
    assign bus.Ry_out  = ry_out_c;
    assign bus.A_in    = a_in_c;
    assign bus.G_in    = g_in_c;
    assign bus.G_out   = g_out_c;
    assign bus.Extern  = extern_c;
    assign bus.AddXor  = add_xor_c;
    assign bus.done    = done_c;
    assign bus.illegal = illegal_c;
    assign bus.busy    = (state != IDLE) && !done_c;

endmodule
